// File: rtl/regfile_dump_pkg.sv
// Shared constants, state encoding and output word layout for the register-file dump reader.
package regfile_dump_pkg;

  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned NUM_REGS = 1 << ADDR_W;
  localparam int unsigned CNT_W    = ADDR_W + 1;

  localparam logic [ADDR_W-1:0] CSUM_ADDR = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CSUM  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              last;
    logic              is_csum;
  } dump_word_t;

  // Words in an inclusive, possibly wrapping range: 1..NUM_REGS.
  function automatic logic [CNT_W-1:0] range_len(input logic [ADDR_W-1:0] first,
                                                 input logic [ADDR_W-1:0] last);
    return CNT_W'(ADDR_W'(last - first)) + CNT_W'(1);
  endfunction

  // Next register index, wrapping at the top of the file.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr);
    return ADDR_W'((32'(addr) + 32'd1) % NUM_REGS);
  endfunction

endpackage

// File: rtl/rf_dump_out_reg.sv
// Single-entry valid/ready output holding register for the dump stream.
module rf_dump_out_reg
  import regfile_dump_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       load,
  input  dump_word_t word,
  input  logic       ready,
  output logic       valid,
  output dump_word_t out_word,
  output logic       slot_free
);

  // A load takes priority over a drain so a word can be replaced on its handshake cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid    <= 1'b0;
      out_word <= '0;
    end else if (clear) begin
      valid            <= 1'b0;
      out_word.last    <= 1'b0;
      out_word.is_csum <= 1'b0;
    end else if (load) begin
      valid    <= 1'b1;
      out_word <= word;
    end else if (valid && ready) begin
      valid            <= 1'b0;
      out_word.last    <= 1'b0;
      out_word.is_csum <= 1'b0;
    end
  end

  assign slot_free = !valid || ready;

endmodule

// File: rtl/regfile_dump_reader.sv
// Debug dump engine: walks a register range through a spare read port and streams it out.
// Optional trailing XOR checksum word when REGFILE_DUMP_CSUM_EN is defined.
module regfile_dump_reader
  import regfile_dump_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rf_read_add,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [ADDR_W-1:0] dump_addr,
  output logic              dump_last,
  output logic              dump_is_csum,
  output logic              busy,
  output logic              done
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic              done_d;
  logic              load, clear, slot_free;
  dump_word_t        load_word, out_word;
`ifdef REGFILE_DUMP_CSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      busy        <= (state_d != IDLE);
      done        <= done_d;
    end
  end

`ifdef REGFILE_DUMP_CSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) csum_q <= '0;
    else     csum_q <= csum_d;
  end
`endif

  // Next-state, address walk and output-register load control.
  always_comb begin
    state_d           = state_q;
    cur_addr_d        = cur_addr_q;
    remaining_d       = remaining_q;
    done_d            = 1'b0;
    load              = 1'b0;
    clear             = 1'b0;
    load_word         = '0;
    load_word.data    = rf_read_data;
    load_word.addr    = cur_addr_q;
`ifdef REGFILE_DUMP_CSUM_EN
    csum_d            = csum_q;
`endif
    if (abort) begin
      state_d = IDLE;
      clear   = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d     = RUN;
            cur_addr_d  = first_addr;
            remaining_d = range_len(first_addr, last_addr);
`ifdef REGFILE_DUMP_CSUM_EN
            csum_d      = '0;
`endif
          end
        end
        RUN: begin
          if (slot_free) begin
            load        = 1'b1;
            cur_addr_d  = next_addr(cur_addr_q);
            remaining_d = remaining_q - CNT_W'(1);
`ifdef REGFILE_DUMP_CSUM_EN
            csum_d      = csum_q ^ rf_read_data;
            if (remaining_q == CNT_W'(1)) state_d = CSUM;
`else
            if (remaining_q == CNT_W'(1)) begin
              load_word.last = 1'b1;
              state_d        = FLUSH;
            end
`endif
          end
        end
        CSUM: begin
`ifdef REGFILE_DUMP_CSUM_EN
          if (slot_free) begin
            load              = 1'b1;
            load_word.data    = csum_q;
            load_word.addr    = CSUM_ADDR;
            load_word.last    = 1'b1;
            load_word.is_csum = 1'b1;
            state_d           = FLUSH;
          end
`else
          state_d = IDLE;
`endif
        end
        FLUSH: begin
          if (dump_valid && dump_ready) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  rf_dump_out_reg u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .load      (load),
    .word      (load_word),
    .ready     (dump_ready),
    .valid     (dump_valid),
    .out_word  (out_word),
    .slot_free (slot_free)
  );

  assign rf_read_add  = cur_addr_q;
  assign dump_data    = out_word.data;
  assign dump_addr    = out_word.addr;
  assign dump_last    = out_word.last;
  assign dump_is_csum = out_word.is_csum;

endmodule
